// File: rtl/rr_lock_arbiter.sv
// ============================================================================
// Module   : rr_lock_arbiter
// Brief    : Output-port arbiter that locks a grant for a whole wormhole
//            packet; round-robin or fixed priority, registered outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef NPORT
`define NPORT 5
`endif

module rr_lock_arbiter #(
    parameter int size        = `NPORT,
    parameter int ROUND_ROBIN = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [size-1:0]         i_requests,
    input  logic                    i_enable,
    input  logic                    i_release,
    output logic                    o_isOutputSelected,
    output logic [$clog2(size)-1:0] o_selectedOutput,
    output logic [size-1:0]         o_grant,
    output logic                    o_locked
);

    localparam int c_IDX_W = $clog2(size);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   w_ptr_next;
    logic [c_IDX_W-1:0]   r_sel;
    logic [c_IDX_W-1:0]   w_sel_next;
    logic [size-1:0]      r_grant;
    logic [size-1:0]      w_grant_next;

    logic [c_IDX_W-1:0]   w_winner;
    logic                 w_found;
    logic [size-1:0]      w_winner_onehot;
    logic                 w_event;
    logic                 w_leave;
    int                   w_start;
    int                   w_dist;
    int                   w_best;

    // Winner is the requester at the smallest distance after the start
    // index, wrapping modulo size (not modulo 2^width).
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_best   = size;
        w_dist   = 0;
        w_start  = (ROUND_ROBIN != 0) ? int'(r_ptr) : size - 1;
        for (int i = 0; i < size; i++) begin
            w_dist = (i > w_start) ? (i - w_start - 1) : (i + size - w_start - 1);
            if (i_requests[i] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = c_IDX_W'(i);
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_winner_onehot           = '0;
        w_winner_onehot[w_winner] = 1'b1;
    end

    assign w_event = i_enable & w_found;
    // A dropped request from the granted port aborts the packet like a release.
    assign w_leave = i_release | ~i_requests[r_sel];

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_sel_next   = r_sel;
        w_grant_next = r_grant;
        case (r_state)
            ST_IDLE: begin
                if (w_event) begin
                    w_state_next = ST_LOCKED;
                    w_sel_next   = w_winner;
                    w_grant_next = w_winner_onehot;
                    w_ptr_next   = w_winner;
                end else begin
                    w_sel_next   = '0;
                    w_grant_next = '0;
                end
            end
            ST_LOCKED: begin
                if (w_leave) begin
                    if (w_event) begin
                        w_state_next = ST_LOCKED;
                        w_sel_next   = w_winner;
                        w_grant_next = w_winner_onehot;
                        w_ptr_next   = w_winner;
                    end else begin
                        w_state_next = ST_IDLE;
                        w_sel_next   = '0;
                        w_grant_next = '0;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_sel_next   = '0;
                w_grant_next = '0;
            end
        endcase
    end

    // Reset pointer to size-1 so port 0 is searched first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_IDX_W'(size - 1);
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_sel   <= w_sel_next;
            r_grant <= w_grant_next;
        end
    end

    assign o_isOutputSelected = (r_state == ST_LOCKED);
    assign o_locked           = (r_state == ST_LOCKED);
    assign o_selectedOutput   = r_sel;
    assign o_grant            = r_grant;

endmodule

`default_nettype wire

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Parametrised output-port arbiter for the NoC router switch allocator, successor to the combinational fixed-priority arbiter. It selects one of `size` input-port requests and holds (locks) that grant for a whole packet until a release (tail-flit) strobe, so wormhole packets are never interleaved. Arbitration is round-robin by default, giving starvation-free fairness, or fixed-priority when configured. Outputs are registered and the block sits between the input buffers' route requests and the crossbar select.

## Interface
- `size`, default `` `NPORT ``: number of requesting ports, ≥2; need not be a power of two.
- `ROUND_ROBIN`, default 1: 1 = rotating priority; 0 = fixed priority, lowest index wins.
- `i_clk` in, 1: clock; all state changes on the rising edge.
- `i_rst` in, 1: reset, synchronous and active-high.
- `i_requests` in, `size`: per-port request, bit i = port i.
- `i_enable` in, 1: arbitration allowed, i.e. the output port can accept a new packet.
- `i_release` in, 1: tail flit of the granted packet transferred this cycle.
- `o_isOutputSelected` out, 1: a grant is active.
- `o_selectedOutput` out, `$clog2(size)`: index of the granted port.
- `o_grant` out, `size`: one-hot grant; all zero when no grant.
- `o_locked` out, 1: FSM is in LOCKED; equals `o_isOutputSelected`.

## Operation
- FSM has two states.
  - IDLE: no grant.
  - LOCKED: one port holds the output.
- Priority pointer `ptr`, width `$clog2(size)`, records the last winner.
  - Round-robin search order is `ptr+1, ptr+2, … ptr`, wrapping from `size-1` to 0. Modulo is `size`, not 2^width.
  - With `ROUND_ROBIN=0` the search order is always 0..`size-1` and `ptr` is unused.
- Arbitration event: in IDLE with `i_enable`=1 and `i_requests`≠0, the first requesting index in search order wins.
  - Next state is LOCKED.
  - `o_selectedOutput` = winner, `o_grant` = one-hot(winner).
  - `ptr` is set to the winner.
- In IDLE with `i_enable`=0 or no requests: stay IDLE and hold all outputs at 0.
- LOCKED, release conditions: leave the lock if `i_release`=1, or if the granted port's request bit drops (abort).
  - If either condition holds and an arbitration event is also possible in the same cycle, re-arbitrate immediately (back-to-back, no bubble) and stay LOCKED with the new winner.
  - The search starts after the old winner, so the old winner wins again only if it is the sole requester.
  - If either condition holds with no event possible, go to IDLE.
- LOCKED otherwise: hold the grant. `i_enable` and other requests are ignored.
- Simultaneous release and abort: treated as a single release.
- Grant outputs are only ever zero or exactly one-hot; `o_grant[o_selectedOutput]`=1 whenever `o_isOutputSelected`=1.

## Timing
- Reset values: state IDLE, `o_isOutputSelected`=0, `o_locked`=0, `o_grant`=0, `o_selectedOutput`=0, `ptr`=`size-1` (so port 0 has top priority after reset).
- Latency: request sampled at edge N → grant visible after edge N (cycle N+1). This is one cycle, registered, with no combinational path from inputs to outputs.
- Release at cycle M:
  - Old grant is removed from cycle M+1.
  - A back-to-back winner is visible in cycle M+1.
  - If there is no winner, outputs are 0 in M+1 and the next grant comes at the earliest in M+2.
- Reset mid-lock: `i_rst` sampled high overrides every other input. Outputs and `ptr` return to reset values in the next cycle. No grant is held across reset.
- `i_release` while IDLE is ignored.

## Test plan
- Reset: hold `i_rst` 2 cycles with `i_requests`=5'b11111 and `i_enable`=1. Outputs stay 0 throughout. One cycle after reset release, the grant goes to idx 0 (`o_grant`=00001).
- Lock hold (`size`=5): `i_requests`=5'b10110 with enable → next cycle idx 1, `o_grant`=00010. Grant is unchanged for 3 cycles while requests toggle. Pulse `i_release` → next cycle idx 2 back-to-back.
- Round-robin wrap: all five request continuously, `i_release` every grant cycle → grant sequence 0,1,2,3,4,0,1, one grant per cycle.
- Fixed mode (`ROUND_ROBIN`=0): same stimulus → winner is always idx 0. Then drop bit 0 → winner is always idx 1.
- Abort and enable: grant idx 3, then clear `i_requests[3]` with `i_enable`=0 → next cycle all outputs 0 and IDLE. Raise `i_enable` → idx 4 if requesting (pointer was 3), otherwise the next index in wrap order.
- Reset mid-lock: assert `i_rst` while locked on idx 2 → next cycle outputs are 0. After reset, all-requests → idx 0, confirming `ptr` was reinitialised.
